// File: rtl/vga_layer_mux.sv
// vga_layer_mux: priority compositor for a stack of video layers.
// Picks the highest-priority enabled layer (layer 0 wins), falls back to a
// background colour, and offers a background-only mode, a test-bar mode and
// a layer-index debug mode. Layer mask and mode are double-buffered: writes
// land in shadow registers and are copied to the active registers at frame start.
module vga_layer_mux #(
    parameter int LAYERS    = 4,
    parameter int BPC       = 2,
    parameter int BAR_SHIFT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      visible,
    input  logic [LAYERS-1:0]         layer_en,
    input  logic [LAYERS*3*BPC-1:0]   layer_rgb,
    input  logic [3*BPC-1:0]          bg_rgb,
    input  logic                      cfg_we,
    input  logic [LAYERS-1:0]         cfg_mask,
    input  logic [1:0]                cfg_mode,
    output logic [3*BPC-1:0]          out_rgb,
    output logic                      out_visible,
    output logic [3:0]                out_layer,
    output logic                      cfg_pending
);

    localparam int W = 3 * BPC;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_BG_ONLY = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_INDEX   = 2'd3
    } mode_e;

    logic [LAYERS-1:0] shadow_mask_q, shadow_mask_d;
    logic [1:0]        shadow_mode_q, shadow_mode_d;
    logic [LAYERS-1:0] active_mask_q, active_mask_d;
    logic [1:0]        active_mode_q, active_mode_d;
    logic              pending_q, pending_d;
    logic [10:0]       hcount_q, hcount_d;
    logic [W-1:0]      out_rgb_q, out_rgb_d;
    logic              out_visible_q, out_visible_d;
    logic [3:0]        out_layer_q, out_layer_d;

    logic              found;
    logic [3:0]        win_idx;
    logic [W-1:0]      win_rgb;
    logic [2:0]        bar;
    logic [W-1:0]      bar_rgb;
    logic [BPC-1:0]    idx_chan;

    // Shadow/active config: a write in the same cycle as frame_start goes
    // straight to the active registers and leaves nothing pending.
    always_comb begin
        shadow_mask_d = shadow_mask_q;
        shadow_mode_d = shadow_mode_q;
        active_mask_d = active_mask_q;
        active_mode_d = active_mode_q;
        pending_d     = pending_q;
        if (cfg_we) begin
            shadow_mask_d = cfg_mask;
            shadow_mode_d = cfg_mode;
            pending_d     = 1'b1;
        end
        if (frame_start) begin
            active_mask_d = cfg_we ? cfg_mask : shadow_mask_q;
            active_mode_d = cfg_we ? cfg_mode : shadow_mode_q;
            pending_d     = 1'b0;
        end
    end

    // Horizontal pixel counter: restarts on blanking, the pre-increment value labels the current pixel.
    always_comb begin
        hcount_d = visible ? hcount_q + 11'd1 : 11'd0;
    end

    // Priority search; scanning downward leaves the lowest enabled index as the winner.
    always_comb begin
        found   = 1'b0;
        win_idx = 4'(LAYERS);
        win_rgb = '0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && active_mask_q[i]) begin
                found   = 1'b1;
                win_idx = i[3:0];
                win_rgb = layer_rgb[i*W +: W];
            end
        end
    end

    // Test-bar colour from the bar number, and the winner index squeezed into one channel.
    always_comb begin
        bar     = hcount_q[BAR_SHIFT+2:BAR_SHIFT];
        bar_rgb = {{BPC{bar[2]}}, {BPC{bar[1]}}, {BPC{bar[0]}}};
        idx_chan = '0;
        for (int b = 0; b < BPC; b++) begin
            idx_chan[b] = (b < 4) ? win_idx[b % 4] : 1'b0;
        end
    end

    // Output selection by active mode; blanking forces black and the "no source" index.
    always_comb begin
        out_rgb_d     = '0;
        out_layer_d   = 4'hF;
        out_visible_d = visible;
        if (visible) begin
            case (mode_e'(active_mode_q))
                MODE_NORMAL: begin
                    out_rgb_d   = found ? win_rgb : bg_rgb;
                    out_layer_d = win_idx;
                end
                MODE_BG_ONLY: begin
                    out_rgb_d   = bg_rgb;
                    out_layer_d = 4'(LAYERS);
                end
                MODE_BARS: begin
                    out_rgb_d   = bar_rgb;
                    out_layer_d = 4'hF;
                end
                MODE_INDEX: begin
                    out_rgb_d   = found ? {3{idx_chan}} : '0;
                    out_layer_d = win_idx;
                end
                default: begin
                    out_rgb_d   = '0;
                    out_layer_d = 4'hF;
                end
            endcase
        end
    end

    // State registers; reset wins over any config write or frame start in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_mask_q <= '1;
            shadow_mode_q <= 2'd0;
            active_mask_q <= '1;
            active_mode_q <= 2'd0;
            pending_q     <= 1'b0;
            hcount_q      <= 11'd0;
            out_rgb_q     <= '0;
            out_visible_q <= 1'b0;
            out_layer_q   <= 4'hF;
        end else begin
            shadow_mask_q <= shadow_mask_d;
            shadow_mode_q <= shadow_mode_d;
            active_mask_q <= active_mask_d;
            active_mode_q <= active_mode_d;
            pending_q     <= pending_d;
            hcount_q      <= hcount_d;
            out_rgb_q     <= out_rgb_d;
            out_visible_q <= out_visible_d;
            out_layer_q   <= out_layer_d;
        end
    end

    assign out_rgb     = out_rgb_q;
    assign out_visible = out_visible_q;
    assign out_layer   = out_layer_q;
    assign cfg_pending = pending_q;

endmodule
